ahb_resp_mux: RTL and testbench
===============================

Name: ahb_resp_mux

Overview:
- Data-phase controller for the AHB-Lite subordinate fabric. Sits between the address decoder's HSEL outputs and the manager.
- Registers the address-phase selection. Steers HRDATA, HREADY and HRESP from the selected subordinate back to the manager, and drives the bus-level HREADY to every subordinate.
- Contains a default-subordinate FSM. Active transfers to unmapped regions (region codes 0 and 7) get a two-cycle ERROR response.

Parameters:
- DATA_WIDTH, 32, width of read data per subordinate.
- NO_OF_SUBORDINATES, 6, number of mapped subordinates (HSEL vector width).

Ports:
- HCLK  input  1  bus clock; all state updates on rising edge.
- HRESET  input  1  synchronous, active-high reset.
- HSEL  input  NO_OF_SUBORDINATES  one-hot address-phase select from decoder. Bit map: 0=HSEL1, 1=HSEL2, 2=HSEL3, 3=HSELd, 4=HSEL_p_r, 5=HSEL_p_wr.
- HTRANS  input  2  manager transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HRDATA_S  input  NO_OF_SUBORDINATES*DATA_WIDTH  concatenated subordinate read data; slice i = subordinate i.
- HREADYOUT_S  input  NO_OF_SUBORDINATES  per-subordinate ready.
- HRESP_S  input  NO_OF_SUBORDINATES  per-subordinate response (0=OKAY, 1=ERROR).
- HRDATA  output  DATA_WIDTH  muxed read data to manager.
- HREADY  output  1  muxed ready; also fed to all subordinates as their HREADY input.
- HRESP  output  1  muxed response to manager.

Behaviour:
- Clock and reset: one clock, HCLK; reset HRESET is synchronous and active-high. While HRESET=1 at an edge: sel_q=0, FSM=D_IDLE.
- Outputs after reset: HREADY=1, HRESP=0, HRDATA=0.
- Address-phase capture: on an edge with HREADY=1, sel_q <= HSEL. When HREADY=0, sel_q holds, so a wait-stated data phase keeps its subordinate.
- Multi-hot HSEL: lowest set index wins when muxing. The one-hot requirement is enforced by assertion, not by logic.
- Unmapped active transfer (unmapped_act): HREADY=1 & HTRANS[1]=1 & HSEL=0.
- Default-subordinate FSM states: D_IDLE, D_ERR1, D_ERR2.
  - D_IDLE -> D_ERR1 on unmapped_act; else stay.
  - D_ERR1 -> D_ERR2 unconditionally. Outputs: HREADY=0, HRESP=1.
  - D_ERR2: HREADY=1, HRESP=1, and a new address phase is sampled. Go to D_ERR1 on unmapped_act, else D_IDLE.
- IDLE or BUSY to an unmapped region: zero-wait OKAY; FSM stays D_IDLE.
- Output mux, priority order:
  1. FSM in D_ERR1/D_ERR2: FSM outputs, HRDATA=0.
  2. sel_q has bit i set: HRDATA=HRDATA_S slice i, HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i].
  3. sel_q=0: HREADY=1, HRESP=0, HRDATA=0.
- Output latency: combinational from registered state and subordinate inputs. No added wait states for mapped subordinates.
- Subordinate ERROR: passed through unchanged (the subordinate owns its two-cycle sequence). sel_q holds during its HREADY=0 cycle.
- Back-to-back transfers:
  - mapped then unmapped: the mapped data phase completes, then the FSM enters D_ERR1 on the same edge sel_q clears to 0.
  - unmapped then mapped: in D_ERR2, sel_q <= new HSEL and the FSM goes to D_IDLE.
- Reset mid-operation: any state aborts to D_IDLE with sel_q=0 on the next edge; outputs return to reset values.
- Widths: the slice index for HRDATA_S is i*DATA_WIDTH; no arithmetic beyond constant slicing.

Decomposition:
- Shared package ahb_pkg: HTRANS encodings (HTRANS_IDLE/BUSY/NONSEQ/SEQ), HRESP_OKAY/HRESP_ERROR, default-subordinate state enum, HSEL bit-index constants.
- Sub-module ahb_default_sub: holds the D_IDLE/D_ERR1/D_ERR2 FSM.
  - Inputs: HCLK, HRESET, HREADY, HTRANS, and the no-select signal.
  - Outputs: def_active, def_hready, def_hresp.
- ahb_resp_mux holds sel_q and the output mux.

Test Plan:
- Reset: assert HRESET for 2 cycles with HSEL=6'b000100 -> after release, HREADY=1, HRESP=0, HRDATA=0, sel_q=0.
- Mapped read, HSEL2: NONSEQ with HSEL=6'b000010, HRDATA_S slice 1=32'hCAFE_0001, HREADYOUT_S[1] low for 2 cycles -> HREADY=0 for 2 cycles, then HREADY=1 with HRDATA=32'hCAFE_0001, HRESP=0. sel_q stable throughout.
- Unmapped NONSEQ: HSEL=0, HTRANS=2 -> next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1, then OKAY.
- Unmapped IDLE: HSEL=0, HTRANS=0 -> HREADY=1, HRESP=0, no ERROR cycles.
- Back-to-back: unmapped NONSEQ, then HSEL=6'b100000 sampled in D_ERR2 -> ERROR pair, then the HSEL_p_wr data phase returns HREADYOUT_S[5]/HRESP_S[5].
- Subordinate ERROR pass-through with mid-op reset: HSEL_p_r returns HRESP=1 with HREADYOUT=0, and HRESET is pulsed during that cycle -> next edge HREADY=1, HRESP=0, FSM=D_IDLE.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-subordinate state constants
// used by the response mux and its error-responder FSM.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef logic [1:0] dsub_state_t;
  localparam dsub_state_t D_IDLE = 2'd0;
  localparam dsub_state_t D_ERR1 = 2'd1;
  localparam dsub_state_t D_ERR2 = 2'd2;

  localparam int HSEL1_IDX     = 0;
  localparam int HSEL2_IDX     = 1;
  localparam int HSEL3_IDX     = 2;
  localparam int HSELD_IDX     = 3;
  localparam int HSEL_P_R_IDX  = 4;
  localparam int HSEL_P_WR_IDX = 5;

endpackage

// File: rtl/ahb_default_sub.sv
// Default subordinate: answers active transfers to unmapped regions with
// the two-cycle AHB ERROR response.
module ahb_default_sub
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HREADY,
  input  logic [1:0] HTRANS,
  input  logic       no_sel,
  output logic       def_active,
  output logic       def_hready,
  output logic       def_hresp
);

  dsub_state_t state;
  dsub_state_t state_next;
  logic        unmapped_act;

  assign unmapped_act = HREADY && no_sel &&
                        ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  always_comb begin
    state_next = D_IDLE;
    case (state)
      D_IDLE:  state_next = unmapped_act ? D_ERR1 : D_IDLE;
      D_ERR1:  state_next = D_ERR2;
      D_ERR2:  state_next = unmapped_act ? D_ERR1 : D_IDLE;
      default: state_next = D_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= D_IDLE;
    else        state <= state_next;
  end

  // ERR1 stalls the manager; ERR2 completes the response and lets a new address phase in.
  assign def_active = (state == D_ERR1) || (state == D_ERR2);
  assign def_hready = (state != D_ERR1);
  assign def_hresp  = def_active ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite data-phase response mux: registers the address-phase select and
// steers the selected subordinate's data, ready and response to the manager.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int NO_OF_SUBORDINATES = 6
) (
  input  logic                                     HCLK,
  input  logic                                     HRESET,
  input  logic [NO_OF_SUBORDINATES-1:0]            HSEL,
  input  logic [1:0]                               HTRANS,
  input  logic [NO_OF_SUBORDINATES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NO_OF_SUBORDINATES-1:0]            HREADYOUT_S,
  input  logic [NO_OF_SUBORDINATES-1:0]            HRESP_S,
  output logic [DATA_WIDTH-1:0]                    HRDATA,
  output logic                                     HREADY,
  output logic                                     HRESP
);

  logic [NO_OF_SUBORDINATES-1:0] sel_q;
  logic                          no_sel;
  logic                          def_active;
  logic                          def_hready;
  logic                          def_hresp;

  assign no_sel = (HSEL == '0);

  // Hold the selection across wait states so a stalled data phase keeps its subordinate.
  always_ff @(posedge HCLK) begin
    if (HRESET)      sel_q <= '0;
    else if (HREADY) sel_q <= HSEL;
  end

  ahb_default_sub u_default_sub (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HREADY     (HREADY),
    .HTRANS     (HTRANS),
    .no_sel     (no_sel),
    .def_active (def_active),
    .def_hready (def_hready),
    .def_hresp  (def_hresp)
  );

  // Scanning downwards lets the lowest set index win if the select is ever multi-hot.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    HRDATA = '0;
    if (def_active) begin
      HREADY = def_hready;
      HRESP  = def_hresp;
    end else begin
      for (int i = NO_OF_SUBORDINATES - 1; i >= 0; i--) begin
        if (sel_q[i]) begin
          HREADY = HREADYOUT_S[i];
          HRESP  = HRESP_S[i];
          HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  hsel_onehot: assert property (@(posedge HCLK) disable iff (HRESET)
                                HREADY |-> $onehot0(HSEL));

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Randomized and directed checks of ahb_resp_mux against a transaction-level
// model that tracks the selected subordinate and a pending error countdown.
module tb_ahb_resp_mux;
  import ahb_pkg::*;

  localparam int DW = 32;
  localparam int NS = 6;

  logic              HCLK;
  logic              HRESET;
  logic [NS-1:0]     HSEL;
  logic [1:0]        HTRANS;
  logic [NS*DW-1:0]  HRDATA_S;
  logic [NS-1:0]     HREADYOUT_S;
  logic [NS-1:0]     HRESP_S;
  logic [DW-1:0]     HRDATA;
  logic              HREADY;
  logic              HRESP;

  int  testsRun;
  int  testsFailed;
  int  mSel;
  int  mErr;
  bit  mValid;
  bit  pinData;

  ahb_resp_mux #(.DATA_WIDTH(DW), .NO_OF_SUBORDINATES(NS)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSEL        (HSEL),
    .HTRANS      (HTRANS),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle, check outputs against the model, then advance the model past the edge.
  task automatic applyStimulus(input bit rst, input logic [NS-1:0] hsel,
                               input logic [1:0] htrans, input logic [NS-1:0] rdy,
                               input logic [NS-1:0] rsp);
    logic          expReady;
    logic          expResp;
    logic [DW-1:0] expData;
    int            low;
    @(negedge HCLK);
    HRESET      = rst;
    HSEL        = hsel;
    HTRANS      = htrans;
    HREADYOUT_S = rdy;
    HRESP_S     = rsp;
    for (int k = 0; k < NS; k++) HRDATA_S[k*DW +: DW] = $urandom;
    if (pinData) HRDATA_S[1*DW +: DW] = 32'hCAFE_0001;
    #1;
    if (mErr == 2)      begin expReady = 1'b0; expResp = 1'b1; expData = '0; end
    else if (mErr == 1) begin expReady = 1'b1; expResp = 1'b1; expData = '0; end
    else if (mSel >= 0) begin
      expReady = rdy[mSel];
      expResp  = rsp[mSel];
      expData  = HRDATA_S[mSel*DW +: DW];
    end else begin expReady = 1'b1; expResp = 1'b0; expData = '0; end
    if (mValid) begin
      checkOutput("model_hready", {31'b0, HREADY}, {31'b0, expReady});
      checkOutput("model_hresp",  {31'b0, HRESP},  {31'b0, expResp});
      checkOutput("model_hrdata", HRDATA, expData);
    end
    if (rst) begin
      mSel = -1; mErr = 0; mValid = 1'b1;
    end else begin
      low = -1;
      for (int k = NS - 1; k >= 0; k--) if (hsel[k]) low = k;
      if (mErr == 2)                                   mErr = 1;
      else if (expReady && htrans[1] && hsel == '0)    mErr = 2;
      else                                             mErr = 0;
      if (expReady) mSel = low;
    end
  endtask

  initial begin
    logic [NS-1:0] allOk;
    logic [NS-1:0] rsel;
    logic [NS-1:0] rrdy;
    int            idx;
    testsRun = 0; testsFailed = 0;
    mSel = -1; mErr = 0; mValid = 1'b0; pinData = 1'b0;
    allOk = '1;
    HRESET = 1'b1; HSEL = '0; HTRANS = HTRANS_IDLE;
    HRDATA_S = '0; HREADYOUT_S = '1; HRESP_S = '0;

    // Reset held two cycles with a live select, then released.
    applyStimulus(1, 6'b000100, HTRANS_NONSEQ, allOk, '0);
    applyStimulus(1, 6'b000100, HTRANS_NONSEQ, allOk, '0);
    applyStimulus(0, '0, HTRANS_IDLE, allOk, '0);
    checkOutput("rst_hready", {31'b0, HREADY}, 32'd1);
    checkOutput("rst_hresp",  {31'b0, HRESP},  32'd0);
    checkOutput("rst_hrdata", HRDATA, 32'd0);

    // Mapped read to HSEL2 with two wait states.
    pinData = 1'b1;
    applyStimulus(0, 6'b000010, HTRANS_NONSEQ, allOk, '0);
    applyStimulus(0, '0, HTRANS_IDLE, 6'b111101, '0);
    checkOutput("wait1_hready", {31'b0, HREADY}, 32'd0);
    applyStimulus(0, '0, HTRANS_IDLE, 6'b111101, '0);
    checkOutput("wait2_hready", {31'b0, HREADY}, 32'd0);
    applyStimulus(0, '0, HTRANS_IDLE, allOk, '0);
    checkOutput("read_hready", {31'b0, HREADY}, 32'd1);
    checkOutput("read_hrdata", HRDATA, 32'hCAFE_0001);
    checkOutput("read_hresp",  {31'b0, HRESP}, 32'd0);
    pinData = 1'b0;

    // Unmapped NONSEQ: two-cycle ERROR then OKAY.
    applyStimulus(0, '0, HTRANS_NONSEQ, allOk, '0);
    applyStimulus(0, '0, HTRANS_IDLE, allOk, '0);
    checkOutput("err1_hready", {31'b0, HREADY}, 32'd0);
    checkOutput("err1_hresp",  {31'b0, HRESP},  32'd1);
    applyStimulus(0, '0, HTRANS_IDLE, allOk, '0);
    checkOutput("err2_hready", {31'b0, HREADY}, 32'd1);
    checkOutput("err2_hresp",  {31'b0, HRESP},  32'd1);
    applyStimulus(0, '0, HTRANS_IDLE, allOk, '0);
    checkOutput("post_err_hresp", {31'b0, HRESP}, 32'd0);

    // Unmapped IDLE and BUSY are zero-wait OKAY.
    applyStimulus(0, '0, HTRANS_BUSY, allOk, '0);
    applyStimulus(0, '0, HTRANS_IDLE, allOk, '0);
    checkOutput("idle_hready", {31'b0, HREADY}, 32'd1);
    checkOutput("idle_hresp",  {31'b0, HRESP},  32'd0);

    // Unmapped then HSEL_p_wr sampled during ERR2.
    applyStimulus(0, '0, HTRANS_NONSEQ, allOk, '0);
    applyStimulus(0, '0, HTRANS_IDLE, allOk, '0);
    applyStimulus(0, 6'b100000, HTRANS_NONSEQ, allOk, '0);
    checkOutput("b2b_err2_hresp", {31'b0, HRESP}, 32'd1);
    applyStimulus(0, '0, HTRANS_IDLE, 6'b011111, 6'b100000);
    checkOutput("b2b_wr_hready", {31'b0, HREADY}, 32'd0);
    checkOutput("b2b_wr_hresp",  {31'b0, HRESP},  32'd1);
    applyStimulus(0, '0, HTRANS_IDLE, allOk, '0);

    // Subordinate ERROR on HSEL_p_r interrupted by reset.
    applyStimulus(0, 6'b010000, HTRANS_NONSEQ, allOk, '0);
    applyStimulus(1, '0, HTRANS_IDLE, 6'b101111, 6'b010000);
    checkOutput("sub_err_hresp", {31'b0, HRESP}, 32'd1);
    applyStimulus(0, '0, HTRANS_IDLE, 6'b101111, 6'b010000);
    checkOutput("midrst_hready", {31'b0, HREADY}, 32'd1);
    checkOutput("midrst_hresp",  {31'b0, HRESP},  32'd0);

    // Random traffic with one-hot-or-zero selects and occasional resets.
    for (int n = 0; n < 400; n++) begin
      idx  = $urandom_range(0, NS);
      rsel = (idx == NS) ? '0 : (NS'(1) << idx);
      rrdy = NS'($urandom) | NS'($urandom);
      applyStimulus(($urandom_range(0, 49) == 0), rsel, 2'($urandom), rrdy,
                    NS'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
